// File: rtl/rv_regfile_sb.sv
// Register file with N combinational read ports, one write port, post-reset clearing and per-register busy scoreboard.
// Optional write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module rv_regfile_sb #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_READ   = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic                           ready,
  input  logic                           wen,
  input  logic [ADDR_WIDTH-1:0]          waddr,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
  output logic [NUM_READ-1:0]            rbusy,
  input  logic                           iss_valid,
  input  logic [ADDR_WIDTH-1:0]          iss_rd,
  output logic                           busy_any
);

  localparam int   DEPTH = 1 << ADDR_WIDTH;
  localparam logic ZR    = (ZERO_REG != 0);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   clr_idx_q, clr_idx_d;
  logic [DEPTH-1:0]        busy_q, busy_d;
  logic [DATA_WIDTH-1:0]   rf [DEPTH];

  logic                    rf_we;
  logic [ADDR_WIDTH-1:0]   rf_waddr;
  logic [DATA_WIDTH-1:0]   rf_wdata;
  logic                    wr_ok;
  logic                    run;

  assign run   = (state_q == S_RUN);
  assign wr_ok = wen && !(ZR && waddr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
      busy_q    <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    busy_d    = busy_q;
    rf_we     = 1'b0;
    rf_waddr  = waddr;
    rf_wdata  = wdata;
    case (state_q)
      S_CLEAR: begin
        rf_we     = 1'b1;
        rf_waddr  = clr_idx_q;
        rf_wdata  = '0;
        clr_idx_d = clr_idx_q + 1'b1;
        if (clr_idx_q == {ADDR_WIDTH{1'b1}}) state_d = S_RUN;
      end
      default: begin
        rf_we = wr_ok;
        // Clear first so a same-register issue on this edge wins.
        if (wen) busy_d[waddr] = 1'b0;
        if (iss_valid && !(ZR && iss_rd == '0)) busy_d[iss_rd] = 1'b1;
      end
    endcase
  end

  // Storage is deliberately not reset; the clearing pass initialises it.
  always_ff @(posedge clk) begin
    if (rf_we) rf[rf_waddr] <= rf_wdata;
  end

  assign ready    = run;
  assign busy_any = |busy_q;

  for (genvar g = 0; g < NUM_READ; g++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    logic                  rb;

    assign ra = raddr[g*ADDR_WIDTH +: ADDR_WIDTH];

    always_comb begin
      rd = rf[ra];
      rb = busy_q[ra];
      if (ZR && ra == '0) rd = '0;
`ifdef REGFILE_BYPASS_EN
      if (wr_ok && waddr == ra) begin
        rd = wdata;
        rb = 1'b0;
      end
`endif
      if (!run) begin
        rd = '0;
        rb = 1'b0;
      end
    end

    assign rdata[g*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign rbusy[g] = rb;
  end

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Self-checking bench for rv_regfile_sb (default parameters): clearing, read/write, scoreboard, mid-run reset.
module tb_rv_regfile_sb;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic        wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        busy_any;

  int n_chk  = 0;
  int n_fail = 0;

  rv_regfile_sb dut (
    .clk(clk), .rst(rst), .ready(ready), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata), .rbusy(rbusy), .iss_valid(iss_valid),
    .iss_rd(iss_rd), .busy_any(busy_any)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        iss;
    logic [4:0]  iss_rd;
    logic [4:0]  ra0, ra1;
    logic [31:0] e0, e1;
    logic [1:0]  eb;
    logic        ea;
  } vec_t;

  typedef struct {
    logic [31:0] e0, e1;
    logic [1:0]  eb;
    logic        ea;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic vec_t mk(logic w, logic [4:0] wa, logic [31:0] wd, logic is, logic [4:0] ir,
                              logic [4:0] a0, logic [4:0] a1, logic [31:0] e0, logic [31:0] e1,
                              logic [1:0] eb, logic ea);
    vec_t v;
    v.wen = w; v.waddr = wa; v.wdata = wd; v.iss = is; v.iss_rd = ir;
    v.ra0 = a0; v.ra1 = a1; v.e0 = e0; v.e1 = e1; v.eb = eb; v.ea = ea;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    wen = 1'b0; waddr = '0; wdata = '0; iss_valid = 1'b0; iss_rd = '0;
  endtask

  // rst must already be high; holds it over one edge, releases at a negedge and counts clearing edges.
  task automatic release_and_clear(input string tag);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(posedge clk);
      #2;
      chk({tag, "_ready"}, 64'(ready), 64'(k == 32));
      if (k < 32) begin
        chk({tag, "_rd0_clr"}, 64'(rdata[31:0]), 64'h0);
        chk({tag, "_rbusy_clr"}, 64'(rbusy), 64'h0);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    rst = 1'b1;
    idle_inputs();
    raddr = '0;

    // Reset held over two edges; wen/iss asserted during clearing must be ignored.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_ready", 64'(ready), 64'h0);
    chk("reset_busy_any", 64'(busy_any), 64'h0);
    chk("reset_rdata", rdata, 64'h0);
    wen = 1'b1; waddr = 5'd9; wdata = 32'hFFFF; iss_valid = 1'b1; iss_rd = 5'd9;
    raddr = {5'd9, 5'd9};
    release_and_clear("clr1");

    for (int i = 0; i < 32; i++) begin
      raddr = {5'(31 - i), 5'(i)};
      #1;
      chk("clear_rd0", 64'(rdata[31:0]), 64'h0);
      chk("clear_rd1", 64'(rdata[63:32]), 64'h0);
      chk("clear_rbusy", 64'(rbusy), 64'h0);
    end
    chk("clear_busy_any", 64'(busy_any), 64'h0);

    // Each row: inputs driven for one cycle, outputs sampled before the edge that applies them.
    vecs.push_back(mk(1, 5,  32'hDEADBEEF, 0, 0, 1, 2, 0, 0, 2'b00, 0));
    vecs.push_back(mk(1, 0,  32'h00001234, 0, 0, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0));
    vecs.push_back(mk(0, 0,  0,            1, 7, 0, 5, 0, 32'hDEADBEEF, 2'b00, 0));
    vecs.push_back(mk(0, 0,  0,            1, 0, 7, 0, 0, 0, 2'b01, 1));
    vecs.push_back(mk(1, 7,  32'h11111111, 0, 0, 0, 1, 0, 0, 2'b00, 1));
    vecs.push_back(mk(1, 3,  32'h00000055, 1, 3, 7, 0, 32'h11111111, 0, 2'b00, 0));
    vecs.push_back(mk(0, 0,  0,            0, 0, 3, 7, 32'h55, 32'h11111111, 2'b01, 1));
    vecs.push_back(mk(1, 3,  32'h00000066, 1, 4, 4, 5, 0, 32'hDEADBEEF, 2'b00, 1));
    vecs.push_back(mk(0, 0,  0,            0, 0, 3, 4, 32'h66, 0, 2'b10, 1));
    vecs.push_back(mk(0, 0,  0,            1, 4, 4, 3, 0, 32'h66, 2'b01, 1));
    vecs.push_back(mk(1, 4,  32'hCAFEF00D, 0, 0, 3, 3, 32'h66, 32'h66, 2'b00, 1));
    vecs.push_back(mk(1, 9,  32'h0000AAAA, 0, 0, 4, 9, 32'hCAFEF00D, 0, 2'b00, 0));
    vecs.push_back(mk(1, 31, 32'h80000001, 0, 0, 9, 30, 32'hAAAA, 0, 2'b00, 0));
    vecs.push_back(mk(0, 0,  0,            0, 0, 31, 9, 32'h80000001, 32'hAAAA, 2'b00, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      wen = vecs[i].wen; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      iss_valid = vecs[i].iss; iss_rd = vecs[i].iss_rd;
      raddr = {vecs[i].ra1, vecs[i].ra0};
      sb.push_back('{e0: vecs[i].e0, e1: vecs[i].e1, eb: vecs[i].eb, ea: vecs[i].ea});
      #2;
      e = sb.pop_front();
      chk($sformatf("vec%0d_rd0", i), 64'(rdata[31:0]), 64'(e.e0));
      chk($sformatf("vec%0d_rd1", i), 64'(rdata[63:32]), 64'(e.e1));
      chk($sformatf("vec%0d_rbusy", i), 64'(rbusy), 64'(e.eb));
      chk($sformatf("vec%0d_busy_any", i), 64'(busy_any), 64'(e.ea));
    end
    @(negedge clk);
    idle_inputs();

    // Forwarding corner: register 6 busy, written and read in the same cycle.
    iss_valid = 1'b1; iss_rd = 5'd6;
    @(negedge clk);
    idle_inputs();
    wen = 1'b1; waddr = 5'd6; wdata = 32'hA5A5A5A5; raddr = {5'd0, 5'd6};
    #2;
`ifdef REGFILE_BYPASS_EN
    chk("byp_rd0", 64'(rdata[31:0]), 64'hA5A5A5A5);
    chk("byp_rbusy0", 64'(rbusy[0]), 64'h0);
`else
    chk("nobyp_rd0", 64'(rdata[31:0]), 64'h0);
    chk("nobyp_rbusy0", 64'(rbusy[0]), 64'h1);
`endif
    chk("byp_busy_any", 64'(busy_any), 64'h1);
    @(negedge clk);
    idle_inputs();
    #2;
    chk("after_wb6_rd0", 64'(rdata[31:0]), 64'hA5A5A5A5);
    chk("after_wb6_busy_any", 64'(busy_any), 64'h0);

    // Mid-operation reset: regs 1..4 written, reg 2 busy.
    for (int r = 1; r <= 4; r++) begin
      @(negedge clk);
      wen = 1'b1; waddr = 5'(r); wdata = 32'h100 + 32'(r);
    end
    @(negedge clk);
    idle_inputs();
    iss_valid = 1'b1; iss_rd = 5'd2;
    @(negedge clk);
    idle_inputs();
    raddr = {5'd2, 5'd4};
    #2;
    chk("pre_rst_rd0", 64'(rdata[31:0]), 64'h104);
    chk("pre_rst_rbusy", 64'(rbusy), 64'h2);
    chk("pre_rst_busy_any", 64'(busy_any), 64'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(ready), 64'h0);
    chk("mid_rst_busy_any", 64'(busy_any), 64'h0);
    chk("mid_rst_rdata", rdata, 64'h0);
    release_and_clear("clr2");
    for (int r = 1; r <= 4; r++) begin
      raddr = {5'(r), 5'(r)};
      #1;
      chk($sformatf("post_rst_r%0d", r), rdata, 64'h0);
    end
    chk("post_rst_busy_any", 64'(busy_any), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
